axi_4_lite_master: RTL and testbench

- Memory-side AXI4-Lite initiator for the cache.
- Accepts one cache request packet at a time and issues it as a single AXI4-Lite transaction: AW+W+B for writes, AR+R for reads.
- Returns read data, or a write acknowledge, to the cache over a valid/ready response port.
- Request packet layout is the cache packet format: {addr, wdata, wstrb, we}, with bit 0 = we.

---
 rtl/cache_pkg.sv | 39 +++
 rtl/axi_4_lite_master.sv | 209 ++++++++++++++++++++
 tb/tb_axi_4_lite_master.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared widths, AXI response encoding and AXI master state
//               encoding for the cache memory-side interface.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int DATA_BYTES = DATA_WIDTH / 8;
    // Request packet {addr, wdata, wstrb, we}; also the request fifo width.
    localparam int FIFO_WIDTH = ADDR_WIDTH + DATA_WIDTH + DATA_BYTES + 1;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WR_RESP      = 3'd2,
        RD_ADDR      = 3'd3,
        RD_DATA      = 3'd4,
        RESP         = 3'd5
    } axi_mst_state_t;

    // Both error encodings have bit 1 set; the full compare keeps every
    // response bit in use.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (axi_resp_t'(resp) == SLVERR) || (axi_resp_t'(resp) == DECERR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_4_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : axi_4_lite_master
// Description : Memory-side AXI4-Lite initiator for the cache. Takes one
//               request packet at a time, issues it as a single AXI4-Lite
//               transaction (AW+W+B or AR+R) and returns read data or a
//               write acknowledge on a valid/ready response port.
// Revision    : 1.0 - initial release
//
// Ports:
//   aclk_i, arst_i           clock, synchronous active-high reset
//   req_data_i/valid/ready   request packet {addr, wdata, wstrb, we}
//   rsp_data/we/err/valid/ready  response to the cache
//   aw*, w*, b*, ar*, r*     AXI4-Lite master channels
// ============================================================================
module axi_4_lite_master #(
    parameter int         ADDR_WIDTH = cache_pkg::ADDR_WIDTH,
    parameter int         DATA_WIDTH = cache_pkg::DATA_WIDTH,
    parameter int         DATA_BYTES = DATA_WIDTH / 8,
    parameter int         PKT_WIDTH  = ADDR_WIDTH + DATA_WIDTH + DATA_BYTES + 1,
    parameter logic [2:0] PROT       = 3'b000
) (
    input  logic                  aclk_i,
    input  logic                  arst_i,
    // cache request port
    input  logic [PKT_WIDTH-1:0]  req_data_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    // cache response port
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_we_o,
    output logic                  rsp_err_o,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    // AXI write address
    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [ADDR_WIDTH-1:0] awaddr_o,
    output logic [2:0]            awprot_o,
    // AXI write data
    output logic                  wvalid_o,
    input  logic                  wready_i,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [DATA_BYTES-1:0] wstrb_o,
    // AXI write response
    input  logic                  bvalid_i,
    input  logic [1:0]            bresp_i,
    output logic                  bready_o,
    // AXI read address
    output logic                  arvalid_o,
    input  logic                  arready_i,
    output logic [ADDR_WIDTH-1:0] araddr_o,
    output logic [2:0]            arprot_o,
    // AXI read data
    input  logic                  rvalid_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [1:0]            rresp_i,
    output logic                  rready_o
);
    import cache_pkg::*;

    // Packet field positions, LSB first: we, wstrb, wdata, addr.
    localparam int WE_BIT    = 0;
    localparam int STRB_LSB  = 1;
    localparam int WDATA_LSB = STRB_LSB + DATA_BYTES;
    localparam int ADDR_LSB  = WDATA_LSB + DATA_WIDTH;

    axi_mst_state_t          state_q,    state_d;
    logic                    awvalid_q,  awvalid_d;
    logic                    wvalid_q,   wvalid_d;
    logic                    arvalid_q,  arvalid_d;
    logic [ADDR_WIDTH-1:0]   addr_q,     addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,    wdata_d;
    logic [DATA_BYTES-1:0]   wstrb_q,    wstrb_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic                    rsp_we_q,   rsp_we_d;
    logic                    rsp_err_q,  rsp_err_d;

    // A channel counts as done once its valid has already dropped, or its
    // handshake completes this cycle.
    logic aw_done;
    logic w_done;
    assign aw_done = !awvalid_q || awready_i;
    assign w_done  = !wvalid_q  || wready_i;

    always_ff @(posedge aclk_i) begin
        if (arst_i) begin
            state_q    <= IDLE;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rsp_data_q <= '0;
            rsp_we_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            arvalid_q  <= arvalid_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rsp_data_q <= rsp_data_d;
            rsp_we_q   <= rsp_we_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        arvalid_d  = arvalid_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rsp_data_d = rsp_data_q;
        rsp_we_d   = rsp_we_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_data_i[ADDR_LSB  +: ADDR_WIDTH];
                    wdata_d = req_data_i[WDATA_LSB +: DATA_WIDTH];
                    wstrb_d = req_data_i[STRB_LSB  +: DATA_BYTES];
                    if (req_data_i[WE_BIT]) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_ADDR_DATA;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            WR_ADDR_DATA: begin
                if (awvalid_q && awready_i) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && wready_i) begin
                    wvalid_d = 1'b0;
                end
                if (aw_done && w_done) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bvalid_i) begin
                    rsp_err_d  = resp_is_err(bresp_i);
                    rsp_we_d   = 1'b1;
                    rsp_data_d = '0;
                    state_d    = RESP;
                end
            end
            RD_ADDR: begin
                if (arready_i) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rvalid_i) begin
                    rsp_data_d = rdata_i;
                    rsp_err_d  = resp_is_err(rresp_i);
                    rsp_we_d   = 1'b0;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                arvalid_d = 1'b0;
            end
        endcase
    end

    // Ready is gated by reset so the cache never sees a stale accept while
    // the block is being cleared.
    assign req_ready_o = (state_q == IDLE) && !arst_i;

    assign awvalid_o   = awvalid_q;
    assign awaddr_o    = addr_q;
    assign awprot_o    = PROT;
    assign wvalid_o    = wvalid_q;
    assign wdata_o     = wdata_q;
    assign wstrb_o     = wstrb_q;
    assign bready_o    = (state_q == WR_RESP);
    assign arvalid_o   = arvalid_q;
    assign araddr_o    = addr_q;
    assign arprot_o    = PROT;
    assign rready_o    = (state_q == RD_DATA);

    assign rsp_valid_o = (state_q == RESP);
    assign rsp_data_o  = rsp_data_q;
    assign rsp_we_o    = rsp_we_q;
    assign rsp_err_o   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_4_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_4_lite_master
// Description : Self-checking bench for axi_4_lite_master. A behavioural
//               AXI4-Lite slave with a sparse byte-strobed memory supplies
//               responses; expected response data, error flag, latency and
//               handshake counts come from the transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_4_lite_master;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int DB  = 4;
    localparam int PKT = AW + DW + DB + 1;

    logic           aclk_i = 1'b0;
    logic           arst_i;
    logic [PKT-1:0] req_data_i;
    logic           req_valid_i;
    logic           req_ready_o;
    logic [DW-1:0]  rsp_data_o;
    logic           rsp_we_o, rsp_err_o, rsp_valid_o, rsp_ready_i;
    logic           awvalid_o, awready_i;
    logic [AW-1:0]  awaddr_o;
    logic [2:0]     awprot_o;
    logic           wvalid_o, wready_i;
    logic [DW-1:0]  wdata_o;
    logic [DB-1:0]  wstrb_o;
    logic           bvalid_i, bready_o;
    logic [1:0]     bresp_i;
    logic           arvalid_o, arready_i;
    logic [AW-1:0]  araddr_o;
    logic [2:0]     arprot_o;
    logic           rvalid_i, rready_o;
    logic [DW-1:0]  rdata_i;
    logic [1:0]     rresp_i;

    axi_4_lite_master dut (
        .aclk_i      (aclk_i),
        .arst_i      (arst_i),
        .req_data_i  (req_data_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_we_o    (rsp_we_o),
        .rsp_err_o   (rsp_err_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .awvalid_o   (awvalid_o),
        .awready_i   (awready_i),
        .awaddr_o    (awaddr_o),
        .awprot_o    (awprot_o),
        .wvalid_o    (wvalid_o),
        .wready_i    (wready_i),
        .wdata_o     (wdata_o),
        .wstrb_o     (wstrb_o),
        .bvalid_i    (bvalid_i),
        .bresp_i     (bresp_i),
        .bready_o    (bready_o),
        .arvalid_o   (arvalid_o),
        .arready_i   (arready_i),
        .araddr_o    (araddr_o),
        .arprot_o    (arprot_o),
        .rvalid_i    (rvalid_i),
        .rdata_i     (rdata_i),
        .rresp_i     (rresp_i),
        .rready_o    (rready_o)
    );

    always #5 aclk_i = ~aclk_i;

    int n_checks = 0;
    int n_err    = 0;

    // Slave memory: one 32-bit word per address, filled lazily.
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk_i);
        #1;
    endtask

    task automatic slave_idle();
        awready_i = 1'b0; wready_i = 1'b0; arready_i = 1'b0;
        bvalid_i  = 1'b0; rvalid_i = 1'b0;
        bresp_i   = 2'b00; rresp_i = 2'b00; rdata_i = '0;
    endtask

    // One complete transaction. Delays are in cycles the slave waits after
    // seeing the matching valid (aw/w/ar) or ready (b/r) before responding.
    task automatic run_txn(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb,
                           input int aw_dly, input int w_dly, input int ar_dly,
                           input int d_dly, input logic [1:0] resp, input int rsp_dly);
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat, lat;
        int          aw_cnt, w_cnt, ar_cnt, d_cnt, stall;
        int          aw_hs, w_hs, ar_hs, d_hs;
        bit          p_aw, p_w, p_ar, p_d;
        bit          bad_ready, bad_order, bad_stable, bad_drop, bad_payload;
        bit          got, done, aw_seen, w_seen;
        logic [31:0] snap_data;
        logic        snap_we, snap_err;

        exp_err  = resp[1];
        if (we) begin
            exp_data = '0;
            exp_lat  = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + d_dly;
        end else begin
            exp_data = mem_rd(addr);
            exp_lat  = 3 + ar_dly + d_dly;
        end

        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; d_cnt = 0; stall = 0;
        aw_hs = 0; w_hs = 0; ar_hs = 0; d_hs = 0;
        p_aw = 0; p_w = 0; p_ar = 0; p_d = 0;
        bad_ready = 0; bad_order = 0; bad_stable = 0; bad_drop = 0; bad_payload = 0;
        got = 0; done = 0; aw_seen = 0; w_seen = 0; lat = 0;
        snap_data = '0; snap_we = 0; snap_err = 0;

        chk("req_ready_before_accept", req_ready_o, 1);
        req_data_i  = {addr, wdata, wstrb, we};
        req_valid_i = 1'b1;
        tick();
        // During backpressure runs a competing request is held pending.
        req_valid_i = (rsp_dly > 0);
        req_data_i  = {~addr, ~wdata, ~wstrb, ~we};

        for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
            if (p_aw) aw_hs++;
            if (p_w)  w_hs++;
            if (p_ar) ar_hs++;
            if (p_d)  d_hs++;

            if (req_ready_o) bad_ready = 1;
            if (awprot_o !== 3'b000 || arprot_o !== 3'b000) bad_payload = 1;
            if (awvalid_o && awaddr_o !== addr) bad_payload = 1;
            if (wvalid_o && (wdata_o !== wdata || wstrb_o !== wstrb)) bad_payload = 1;
            if (arvalid_o && araddr_o !== addr) bad_payload = 1;
            if (aw_seen && !awvalid_o && aw_hs == 0) bad_drop = 1;
            if (w_seen && !wvalid_o && w_hs == 0) bad_drop = 1;
            if (awvalid_o) aw_seen = 1;
            if (wvalid_o)  w_seen = 1;
            if (bready_o && (aw_hs == 0 || w_hs == 0)) bad_order = 1;
            if (rready_o && ar_hs == 0) bad_order = 1;

            awready_i = awvalid_o && (aw_cnt >= aw_dly);
            if (awvalid_o) aw_cnt++;
            wready_i  = wvalid_o && (w_cnt >= w_dly);
            if (wvalid_o) w_cnt++;
            arready_i = arvalid_o && (ar_cnt >= ar_dly);
            if (arvalid_o) ar_cnt++;
            bvalid_i  = bready_o && (d_cnt >= d_dly);
            bresp_i   = resp;
            rvalid_i  = rready_o && (d_cnt >= d_dly);
            rresp_i   = resp;
            rdata_i   = rvalid_i ? mem_rd(addr) : $urandom;
            if (bready_o || rready_o) d_cnt++;
            p_aw = awvalid_o && awready_i;
            p_w  = wvalid_o  && wready_i;
            p_ar = arvalid_o && arready_i;
            p_d  = (bvalid_i && bready_o) || (rvalid_i && rready_o);

            rsp_ready_i = 1'b0;
            if (rsp_valid_o) begin
                if (!got) begin
                    got = 1; lat = cyc;
                    snap_data = rsp_data_o; snap_we = rsp_we_o; snap_err = rsp_err_o;
                end else if (rsp_data_o !== snap_data || rsp_we_o !== snap_we ||
                             rsp_err_o !== snap_err) begin
                    bad_stable = 1;
                end
                if (stall >= rsp_dly) begin
                    rsp_ready_i = 1'b1;
                    req_valid_i = 1'b0;
                    done = 1;
                end else begin
                    stall++;
                end
            end
            tick();
        end

        rsp_ready_i = 1'b0;
        req_valid_i = 1'b0;
        slave_idle();

        chk("rsp_seen", got, 1);
        chk("rsp_data", snap_data, exp_data);
        chk("rsp_we", snap_we, we);
        chk("rsp_err", snap_err, exp_err);
        chk("latency", lat, exp_lat);
        chk("aw_handshakes", aw_hs, we ? 1 : 0);
        chk("w_handshakes", w_hs, we ? 1 : 0);
        chk("ar_handshakes", ar_hs, we ? 0 : 1);
        chk("resp_handshakes", d_hs, 1);
        chk("req_ready_busy", bad_ready, 0);
        chk("channel_order", bad_order, 0);
        chk("valid_dropped_early", bad_drop, 0);
        chk("payload", bad_payload, 0);
        chk("rsp_stable", bad_stable, 0);
        chk("rsp_valid_after_hs", rsp_valid_o, 0);
        chk("req_ready_after_hs", req_ready_o, 1);

        // A write lands in slave memory only when the slave reports success.
        if (we && !resp[1]) begin
            logic [31:0] old;
            old = mem_rd(addr);
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) old[b*8 +: 8] = wdata[b*8 +: 8];
            mem[addr] = old;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_i      = 1'b1;
        req_valid_i = 1'b0;
        req_data_i  = '0;
        rsp_ready_i = 1'b0;
        slave_idle();
        repeat (3) tick();

        // Reset state
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_valids", {awvalid_o, wvalid_o, arvalid_o, rsp_valid_o}, 4'b0000);
        chk("rst_readies", {bready_o, rready_o}, 2'b00);
        chk("rst_addr", {awaddr_o, araddr_o}, 64'd0);
        chk("rst_wdata", {wdata_o, 28'd0, wstrb_o}, 64'd0);
        chk("rst_rsp", {rsp_data_o, rsp_we_o, rsp_err_o}, 64'd0);
        arst_i = 1'b0;
        #1;
        chk("req_ready_after_rst", req_ready_o, 1);

        // Zero-wait read
        mem[32'h10] = 32'hDEAD_BEEF;
        run_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 0);

        // Write, AW before W, SLVERR
        run_txn(1'b1, 32'h20, 32'h1234_5678, 4'hF, 0, 3, 0, 0, 2'b10, 0);
        // W before AW, then simultaneous
        run_txn(1'b1, 32'h24, 32'hCAFE_F00D, 4'h5, 2, 0, 0, 1, 2'b00, 0);
        run_txn(1'b1, 32'h28, 32'hA5A5_5A5A, 4'hC, 1, 1, 0, 0, 2'b00, 0);
        // Zero-strobe write still goes out on AXI
        run_txn(1'b1, 32'h24, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, 0, 2'b00, 0);
        run_txn(1'b0, 32'h24, 32'h0, 4'h0, 1, 1, 1, 2, 2'b00, 0);
        // Response backpressure with a competing request pending
        run_txn(1'b0, 32'h28, 32'h0, 4'h0, 0, 0, 0, 0, 2'b11, 5);

        // Reset in the middle of a write
        req_data_i  = {32'h40, 32'h1111_2222, 4'hF, 1'b1};
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        tick();
        chk("midwr_awvalid_held", {awvalid_o, wvalid_o}, 2'b11);
        arst_i = 1'b1;
        tick();
        chk("midwr_valids_cleared", {awvalid_o, wvalid_o, arvalid_o, rsp_valid_o}, 4'b0000);
        chk("midwr_req_ready_in_rst", req_ready_o, 0);
        arst_i = 1'b0;
        #1;
        chk("midwr_req_ready_release", req_ready_o, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midwr_no_rsp", {rsp_valid_o, bready_o, awvalid_o}, 3'b000);
        end
        run_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 0);

        // Stray B/R responses while idle
        bvalid_i = 1'b1; rvalid_i = 1'b1; bresp_i = 2'b10; rdata_i = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stray_ignored", {bready_o, rready_o, rsp_valid_o, req_ready_o}, 4'b0001);
        end
        slave_idle();

        // Randomised traffic over a small address window so reads hit writes
        for (int i = 0; i < 24; i++) begin
            logic        r_we;
            logic [31:0] r_addr;
            r_we   = 1'($urandom_range(0, 1));
            r_addr = 32'h100 + 32'($urandom_range(0, 3)) * 4;
            run_txn(r_we, r_addr, $urandom, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), 2'($urandom_range(0, 3)), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
